// File: rtl/trace_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : trace_pkg
// Brief  : Shared types for the commit-trace capture path.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    REG  = 2'd1,
    MEM  = 2'd2
  } rec_kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    rec_kind_e   kind;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : trace_fifo
// Brief  : First-word-fall-through sync FIFO of trace records.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  trace_rec_t               wdata_i,
  output trace_rec_t               rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_aw = $clog2(DEPTH);

  trace_rec_t       r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign valid_o = (r_wr_ptr != r_rd_ptr);
  assign full_o  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign count_o = r_wr_ptr - r_rd_ptr;
  assign rdata_o = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : commit_trace_buffer
// Brief  : Packs retired instructions into trace records and streams them out.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     update_i,
  input  logic [31:0]              pc_wb_i,
  input  logic [31:0]              instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [31:0]              reg_data_i,
  input  logic                     mem_wrt_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_data_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [31:0]              rec_pc_o,
  output logic [31:0]              rec_instr_o,
  output logic [31:0]              rec_addr_o,
  output logic [31:0]              rec_data_o,
  output logic [1:0]               rec_kind_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              retired_o,
  output logic [CNT_W-1:0]         dropped_o,
  output logic                     overflow_o,
  output logic                     done_o
);

  localparam int c_cw = $clog2(DEPTH) + 1;

  trace_state_e     r_state;
  logic [31:0]      r_retired;
  logic [CNT_W-1:0] r_dropped;
  logic             r_overflow;
  logic             r_done;

  trace_rec_t       w_rec;
  trace_rec_t       w_head;
  logic             w_capture;
  logic             w_accept;
  logic             w_pop;
  logic             w_valid;
  logic             w_full;
  logic [c_cw-1:0]  w_count;

  // IDLE may capture on the very cycle update_i first rises.
  assign w_capture = ((r_state == IDLE) || (r_state == RUN)) && update_i && (pc_wb_i != '0);
  assign w_pop     = w_valid && rec_ready_i;
  assign w_accept  = w_capture && (!w_full || w_pop);

  always_comb begin
    w_rec.pc    = pc_wb_i;
    w_rec.instr = instr_i;
    w_rec.kind  = NONE;
    w_rec.addr  = '0;
    w_rec.data  = '0;
    if (mem_wrt_i) begin
      w_rec.kind = MEM;
      w_rec.addr = mem_addr_i;
      w_rec.data = mem_data_i;
    end else if (reg_addr_i != '0) begin
      w_rec.kind = REG;
      w_rec.addr = {27'b0, reg_addr_i};
      w_rec.data = reg_data_i;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_accept),
    .pop_i   (w_pop),
    .wdata_i (w_rec),
    .rdata_o (w_head),
    .valid_o (w_valid),
    .full_o  (w_full),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_retired  <= '0;
      r_dropped  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) r_retired <= r_retired + 32'd1;
      if (w_capture && !w_accept) begin
        if (r_dropped != '1) r_dropped <= r_dropped + CNT_W'(1);
        r_overflow <= 1'b1;
      end
      case (r_state)
        IDLE:    if (update_i)  r_state <= RUN;
        RUN:     if (!update_i) r_state <= DRAIN;
        DRAIN: begin
          if (w_count == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Head fields read as zero when nothing is queued, so reset clears them too.
  assign rec_valid_o = w_valid;
  assign rec_pc_o    = w_valid ? w_head.pc    : '0;
  assign rec_instr_o = w_valid ? w_head.instr : '0;
  assign rec_addr_o  = w_valid ? w_head.addr  : '0;
  assign rec_data_o  = w_valid ? w_head.data  : '0;
  assign rec_kind_o  = w_valid ? w_head.kind  : NONE;
  assign count_o     = w_count;
  assign retired_o   = r_retired;
  assign dropped_o   = r_dropped;
  assign overflow_o  = r_overflow;
  assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_commit_trace_buffer
// Brief  : Directed bench with a queue-based reference model for the trace buffer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        update;
  logic [31:0] pc_wb, instr, reg_data, mem_addr, mem_data;
  logic [4:0]  reg_addr;
  logic        mem_wrt, rec_ready;
  logic        rec_valid, overflow, done;
  logic [31:0] rec_pc, rec_instr, rec_addr, rec_data, retired;
  logic [1:0]  rec_kind;
  logic [4:0]  count;
  logic [CNT_W-1:0] dropped;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .update_i(update), .pc_wb_i(pc_wb),
    .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .mem_wrt_i(mem_wrt), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_pc_o(rec_pc),
    .rec_instr_o(rec_instr), .rec_addr_o(rec_addr), .rec_data_o(rec_data),
    .rec_kind_o(rec_kind), .count_o(count), .retired_o(retired),
    .dropped_o(dropped), .overflow_o(overflow), .done_o(done)
  );

  typedef struct {
    logic [31:0] pc, instr, addr, data;
    logic [1:0]  kind;
  } trec_t;

  trec_t       q[$];
  int unsigned m_ret  = 0;
  int unsigned m_drop = 0;
  bit          m_ovf  = 0;
  int          m_phase = 0;  // 0 idle, 1 run, 2 drain, 3 done
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_pop, m_cap, m_full;
  trec_t       m_rec;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records plus the drain phase, updated per edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_ret = 0; m_drop = 0; m_ovf = 0; m_phase = 0;
    end else begin
      m_pop  = (q.size() != 0) && rec_ready;
      m_cap  = (m_phase < 2) && update && (pc_wb != 0);
      m_full = (q.size() == DEPTH);
      m_rec.pc = pc_wb; m_rec.instr = instr;
      if (mem_wrt) begin
        m_rec.kind = 2; m_rec.addr = mem_addr; m_rec.data = mem_data;
      end else if (reg_addr != 0) begin
        m_rec.kind = 1; m_rec.addr = {27'b0, reg_addr}; m_rec.data = reg_data;
      end else begin
        m_rec.kind = 0; m_rec.addr = 0; m_rec.data = 0;
      end
      if (m_phase == 2 && q.size() == 0) m_phase = 3;
      else if (m_phase == 1 && !update) m_phase = 2;
      else if (m_phase == 0 && update) m_phase = 1;
      if (m_pop) void'(q.pop_front());
      if (m_cap) begin
        if (!m_full || m_pop) begin
          q.push_back(m_rec);
          m_ret++;
        end else begin
          if (m_drop < 32'hFFFF) m_drop++;
          m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", rec_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("pc", rec_pc, q[0].pc);
      chk("instr", rec_instr, q[0].instr);
      chk("kind", rec_kind, q[0].kind);
      chk("addr", rec_addr, q[0].addr);
      chk("data", rec_data, q[0].data);
    end
    chk("count", count, q.size());
    chk("retired", retired, m_ret);
    chk("dropped", dropped, m_drop);
    chk("overflow", overflow, m_ovf);
    chk("done", done, m_phase == 3);
  end

  task automatic cyc();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic drive(input logic u, input logic [31:0] pc, input logic [4:0] ra,
                       input logic [31:0] rd, input logic mw,
                       input logic [31:0] ma, input logic [31:0] md);
    update = u; pc_wb = pc; instr = pc ^ 32'h0000_0013; reg_addr = ra;
    reg_data = rd; mem_wrt = mw; mem_addr = ma; mem_data = md;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, rec_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_retired"}, retired, 0);
    chk({tag, "_dropped"}, dropped, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pc"}, rec_pc, 0);
  endtask

  initial begin
    rstn = 1'b0; rec_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_all_zero("reset");
    @(negedge clk); #1; rstn = 1'b1;

    // Test 1: first REG retirement
    rec_ready = 1'b1;
    drive(1, 32'h8000_0000, 5, 32'h2A, 0, 0, 0);
    cyc();
    chk("t1_valid", rec_valid, 1);
    chk("t1_pc", rec_pc, 32'h8000_0000);
    chk("t1_kind", rec_kind, 1);
    chk("t1_addr", rec_addr, 5);
    chk("t1_data", rec_data, 32'h2A);
    chk("t1_retired", retired, 1);

    // Test 2: store, then a flushed bubble
    drive(1, 32'h8000_0010, 0, 0, 1, 32'h8000_0100, 32'hDEAD_BEEF);
    cyc();
    chk("t2_pc", rec_pc, 32'h8000_0010);
    chk("t2_kind", rec_kind, 2);
    chk("t2_addr", rec_addr, 32'h8000_0100);
    chk("t2_data", rec_data, 32'hDEAD_BEEF);
    chk("t2_retired", retired, 2);
    drive(1, 0, 3, 32'h77, 0, 0, 0);
    cyc();
    chk("t2_bubble_valid", rec_valid, 0);
    chk("t2_bubble_retired", retired, 2);

    // Test 3: overfill with consumer stalled
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h8000_1000 + 4 * i, 5'(i), 32'h100 + i, 0, 0, 0);
      cyc();
    end
    chk("t3_count", count, 16);
    chk("t3_dropped", dropped, 4);
    chk("t3_ovf", overflow, 1);
    chk("t3_retired", retired, 18);
    chk("t3_head", rec_pc, 32'h8000_1000);

    // Test 4: push and pop together on a full FIFO
    rec_ready = 1'b1;
    drive(1, 32'h8000_2000, 9, 32'h99, 0, 0, 0);
    cyc();
    chk("t4_count", count, 16);
    chk("t4_dropped", dropped, 4);
    chk("t4_retired", retired, 19);
    chk("t4_head", rec_pc, 32'h8000_1004);

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (13) cyc();
    chk("t5_pre_count", count, 3);

    // Test 5: update falls with three queued; falling-cycle PC is not captured
    rec_ready = 1'b0;
    drive(0, 32'h8000_3000, 7, 32'h7, 0, 0, 0);
    cyc();
    chk("t5_fall_count", count, 3);
    chk("t5_fall_retired", retired, 19);
    rec_ready = 1'b1;
    repeat (3) cyc();
    chk("t5_empty_count", count, 0);
    chk("t5_not_done_yet", done, 0);
    cyc();
    chk("t5_done", done, 1);
    drive(1, 32'h8000_4000, 7, 32'h7, 0, 0, 0);
    repeat (3) cyc();
    chk("t5_ignored_retired", retired, 19);
    chk("t5_ignored_count", count, 0);
    chk("t5_still_done", done, 1);

    // Test 6: reset from DONE, refill, then async reset mid-cycle
    rstn = 1'b0; #1;
    chk_all_zero("t6_rst1");
    cyc();
    rstn = 1'b1; rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h8000_5000 + 4 * i, 3, 32'h30 + i, 0, 0, 0);
      cyc();
    end
    chk("t6_count5", count, 5);
    chk("t6_retired5", retired, 5);
    #2 rstn = 1'b0; #1;
    chk_all_zero("t6_rst2");
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("t6_idle_count", count, 0);
    drive(1, 32'h8000_6000, 9, 32'h55, 0, 0, 0);
    cyc();
    chk("t6_cap_valid", rec_valid, 1);
    chk("t6_cap_pc", rec_pc, 32'h8000_6000);
    chk("t6_cap_addr", rec_addr, 9);
    chk("t6_cap_retired", retired, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
